bounded_step_counter: RTL and testbench



---
 rtl/bounded_step_counter.sv | 109 ++++++++++
 tb/tb_bounded_step_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bounded_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : bounded_step_counter
// Function : Up/down counter with programmable step, runtime bounds,
//            wrap/saturate policy, and lap (wrap-event) counting.
// Revision : 1.0
// ============================================================================
module bounded_step_counter #(
    parameter int               WIDTH   = 4,
    parameter int               LAPW    = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat,
    output logic [LAPW-1:0]  laps,
    output logic             cfg_err,
    output logic             oor
);

    localparam logic [LAPW-1:0] c_lap_one = {{(LAPW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic [LAPW-1:0]  laps_q, laps_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_step_ok;
    logic             w_hit_bound;

    // One extra bit on both paths: the carry flags overflow past the counter
    // width, the borrow flags underflow below zero.
    assign w_sum     = {1'b0, count_q} + {1'b0, step};
    assign w_diff    = {1'b0, count_q} - {1'b0, step};
    assign w_step_ok = !cfg_err && (step != '0);

    always_comb begin
        if (up) begin
            w_hit_bound = (w_sum > {1'b0, hi});
        end else begin
            w_hit_bound = w_diff[WIDTH] || (w_diff[WIDTH-1:0] < lo);
        end
    end

    always_comb begin
        count_d = count_q;
        laps_d  = laps_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (clr) begin
            count_d = RST_VAL;
            laps_d  = '0;
        end else if (ld) begin
            count_d = d;
        end else if (en && w_step_ok) begin
            if (!w_hit_bound) begin
                count_d = up ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
            end else if (sat_mode) begin
                count_d = up ? hi : lo;
                sat_d   = 1'b1;
            end else begin
                // Wrap jumps to the opposite bound; overshoot is discarded.
                count_d = up ? lo : hi;
                wrap_d  = 1'b1;
                if (laps_q != {LAPW{1'b1}}) begin
                    laps_d = laps_q + c_lap_one;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            laps_q  <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            laps_q  <= laps_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign q       = count_q;
    assign laps    = laps_q;
    assign wrap    = wrap_q;
    assign sat     = sat_q;
    assign tc      = up ? (count_q == hi) : (count_q == lo);
    assign cfg_err = (lo > hi);
    assign oor     = (count_q < lo) || (count_q > hi);

endmodule
`default_nettype wire

// File: tb/tb_bounded_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounded_step_counter
// Function : Scoreboard bench for bounded_step_counter (WIDTH=4, two LAPW).
// Revision : 1.0
// ============================================================================
module tb_bounded_step_counter;

    logic       clk = 1'b0;
    logic       rst, clr, ld, en, up, sat_mode;
    logic [3:0] d, step, lo, hi;

    logic [3:0] q, q2;
    logic       tc, wrap, sat, cfg_err, oor;
    logic       tc2, wrap2, sat2, cfg_err2, oor2;
    logic [7:0] laps;
    logic [1:0] laps2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] q;
        logic       wrap;
        logic       sat;
        logic [7:0] laps;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bounded_step_counter #(.WIDTH(4), .LAPW(8), .RST_VAL(4'd0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .up(up),
        .sat_mode(sat_mode), .step(step), .lo(lo), .hi(hi),
        .q(q), .tc(tc), .wrap(wrap), .sat(sat), .laps(laps),
        .cfg_err(cfg_err), .oor(oor)
    );

    bounded_step_counter #(.WIDTH(4), .LAPW(2), .RST_VAL(4'd0)) u_dut_lap2 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .up(up),
        .sat_mode(sat_mode), .step(step), .lo(lo), .hi(hi),
        .q(q2), .tc(tc2), .wrap(wrap2), .sat(sat2), .laps(laps2),
        .cfg_err(cfg_err2), .oor(oor2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle of control, queue its expected result, compare after the edge.
    task automatic cyc(input string tag, input logic c_clr, input logic c_ld,
                       input logic [3:0] c_d, input logic c_en,
                       input logic [3:0] e_q, input logic e_wrap,
                       input logic e_sat, input logic [7:0] e_laps);
        exp_t e;
        clr = c_clr;
        ld  = c_ld;
        d   = c_d;
        en  = c_en;
        sb.push_back('{q: e_q, wrap: e_wrap, sat: e_sat, laps: e_laps});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q"},     32'(q),     32'(e.q));
            chk({tag, "_wrap"},  32'(wrap),  32'(e.wrap));
            chk({tag, "_sat"},   32'(sat),   32'(e.sat));
            chk({tag, "_laps"},  32'(laps),  32'(e.laps));
            chk({tag, "_laps2"}, 32'(laps2), (e.laps > 8'd3) ? 32'd3 : 32'(e.laps));
            chk({tag, "_q2"},    32'(q2),    32'(e.q));
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; d = '0;
        up = 1'b1; sat_mode = 1'b0; step = 4'd1; lo = 4'd0; hi = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q",    32'(q),    32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        chk("reset_sat",  32'(sat),  32'd0);
        chk("reset_laps", 32'(laps), 32'd0);
        rst = 1'b0;

        // Up wrap
        lo = 4'd2; hi = 4'd9; step = 4'd3; up = 1'b1; sat_mode = 1'b0;
        cyc("upw_ld", 0, 1, 4'd2, 0, 4'd2, 0, 0, 8'd0);
        chk("upw_tc_lo", 32'(tc), 32'd0);
        cyc("upw_e1", 0, 0, 4'd0, 1, 4'd5, 0, 0, 8'd0);
        cyc("upw_e2", 0, 0, 4'd0, 1, 4'd8, 0, 0, 8'd0);
        cyc("upw_e3", 0, 0, 4'd0, 1, 4'd2, 1, 0, 8'd1);
        cyc("upw_idle", 0, 0, 4'd0, 0, 4'd2, 0, 0, 8'd1);

        // Down saturate
        cyc("clr1", 1, 0, 4'd0, 0, 4'd0, 0, 0, 8'd0);
        lo = 4'd3; hi = 4'd12; step = 4'd4; up = 1'b0; sat_mode = 1'b1;
        cyc("dns_ld", 0, 1, 4'd9, 0, 4'd9, 0, 0, 8'd0);
        cyc("dns_e1", 0, 0, 4'd0, 1, 4'd5, 0, 0, 8'd0);
        cyc("dns_e2", 0, 0, 4'd0, 1, 4'd3, 0, 1, 8'd0);
        cyc("dns_e3", 0, 0, 4'd0, 1, 4'd3, 0, 1, 8'd0);
        chk("dns_tc", 32'(tc), 32'd1);
        cyc("dns_idle", 0, 0, 4'd0, 0, 4'd3, 0, 0, 8'd0);

        // Width overflow caught by the carry
        lo = 4'd0; hi = 4'd15; step = 4'd5; up = 1'b1; sat_mode = 1'b0;
        cyc("ovf_ld", 0, 1, 4'd14, 0, 4'd14, 0, 0, 8'd0);
        cyc("ovf_e1", 0, 0, 4'd0, 1, 4'd0, 1, 0, 8'd1);
        cyc("ovf_e2", 0, 0, 4'd0, 1, 4'd5, 0, 0, 8'd1);

        // Priority: ld over en, clr over ld, rst over everything
        cyc("pri_lden", 0, 1, 4'd7, 1, 4'd7, 0, 0, 8'd1);
        cyc("pri_clrld", 1, 1, 4'd4, 1, 4'd0, 0, 0, 8'd0);
        cyc("pri_e1", 0, 0, 4'd0, 1, 4'd5, 0, 0, 8'd0);
        cyc("pri_e2", 0, 0, 4'd0, 1, 4'd10, 0, 0, 8'd0);
        cyc("pri_e3", 0, 0, 4'd0, 1, 4'd15, 0, 0, 8'd0);
        cyc("pri_e4", 0, 0, 4'd0, 1, 4'd0, 1, 0, 8'd1);
        cyc("pri_e5", 0, 0, 4'd0, 1, 4'd5, 0, 0, 8'd1);
        rst = 1'b1;
        cyc("pri_rst", 0, 1, 4'd9, 1, 4'd0, 0, 0, 8'd0);
        rst = 1'b0;

        // Config edges: inverted bounds, zero step, out-of-range load
        lo = 4'd10; hi = 4'd5; step = 4'd3; up = 1'b1;
        cyc("cfg_ld", 0, 1, 4'd7, 0, 4'd7, 0, 0, 8'd0);
        chk("cfg_err_hi", 32'(cfg_err), 32'd1);
        cyc("cfg_hold", 0, 0, 4'd0, 1, 4'd7, 0, 0, 8'd0);
        lo = 4'd2; hi = 4'd9; step = 4'd0;
        #1;
        chk("cfg_err_lo", 32'(cfg_err), 32'd0);
        chk("oor_in",     32'(oor),     32'd0);
        cyc("step0_hold", 0, 0, 4'd0, 1, 4'd7, 0, 0, 8'd0);
        step = 4'd3;
        cyc("oor_ld", 0, 1, 4'd13, 0, 4'd13, 0, 0, 8'd0);
        chk("oor_out", 32'(oor), 32'd1);
        cyc("oor_wrap", 0, 0, 4'd0, 1, 4'd2, 1, 0, 8'd1);
        chk("oor_back", 32'(oor), 32'd0);

        // Clamp at the bound still raises sat
        sat_mode = 1'b1;
        cyc("sat_ld", 0, 1, 4'd9, 0, 4'd9, 0, 0, 8'd1);
        chk("sat_tc_hi", 32'(tc), 32'd1);
        cyc("sat_hold", 0, 0, 4'd0, 1, 4'd9, 0, 1, 8'd1);

        // Lap saturation on the 2-bit instance, back-to-back wraps
        cyc("lap_clr", 1, 0, 4'd0, 0, 4'd0, 0, 0, 8'd0);
        lo = 4'd2; hi = 4'd3; step = 4'd2; up = 1'b1; sat_mode = 1'b0;
        cyc("lap_ld", 0, 1, 4'd2, 0, 4'd2, 0, 0, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc("lap_w", 0, 0, 4'd0, 1, 4'd2, 1, 0, 8'(i));
        end
        cyc("lap_idle", 0, 0, 4'd0, 0, 4'd2, 0, 0, 8'd5);
        chk("lap2_final", 32'(laps2), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
